// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : perf_counter_bank
// Desc   : Bank of NUM_CH event counters with an IDLE/RUN/FROZEN control FSM,
//          sticky overflow flags and a registered readout port. Defining
//          PERF_SNAPSHOT_EN adds a shadow snapshot bank (snap_req/snap_ack/rd_src).
// Rev    : 1.0  initial release
// ============================================================================
module perf_counter_bank #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              freeze,
  input  logic              clr,
  input  logic [NUM_CH-1:0] evt,
  input  logic [3:0]        rd_sel,
  input  logic              rd_src,
  input  logic              snap_req,
  output logic              snap_ack,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_nextState;
  logic              w_countEn;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [CNT_W-1:0]  w_live;
  logic [CNT_W-1:0]  w_rdNext;
  logic [CNT_W-1:0]  r_rdData;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (clr) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start)  w_nextState = ST_RUN;
        ST_RUN:    if (freeze) w_nextState = ST_FROZEN;
        ST_FROZEN: w_nextState = ST_FROZEN;
        default:   w_nextState = ST_IDLE;
      endcase
    end
  end

  // Events in the cycle freeze is first seen are still counted: RUN is the current state.
  assign w_countEn = (r_state == ST_RUN) && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (w_countEn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (evt[i]) begin
          if (r_cnt[i] == c_MAX) begin
            r_ovf[i] <= 1'b1;
            r_cnt[i] <= SAT_MODE ? c_MAX : '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range rd_sel matches no channel and reads back zero.
  always_comb begin
    w_live = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 4'(i)) w_live = r_cnt[i];
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shadow [NUM_CH];
  logic             r_snapAck;
  logic [CNT_W-1:0] w_shadowSel;

  // Shadows take pre-increment values and are untouched by clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
      r_snapAck <= 1'b0;
    end else begin
      r_snapAck <= snap_req;
      if (snap_req) begin
        for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= r_cnt[i];
      end
    end
  end

  always_comb begin
    w_shadowSel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 4'(i)) w_shadowSel = r_shadow[i];
    end
  end

  assign w_rdNext = rd_src ? w_shadowSel : w_live;
  assign snap_ack = r_snapAck;
`else
  logic w_unused;
  assign w_unused = ^{snap_req, rd_src};
  assign w_rdNext = w_live;
  assign snap_ack = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_rdData <= '0;
    else        r_rdData <= w_rdNext;
  end

  assign rd_data = r_rdData;
  assign ovf     = r_ovf;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_perf_counter_bank
// Desc   : Directed + random checks of perf_counter_bank (wrap and saturate
//          instances side by side) against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_perf_counter_bank;

  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;
  localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, freeze, clr, rd_src, snap_req;
  logic [NUM_CH-1:0] evt;
  logic [3:0]        rd_sel;
  logic              ackW, ackS;
  logic [CNT_W-1:0]  rdW, rdS;
  logic [NUM_CH-1:0] ovfW, ovfS;
  logic [1:0]        stW, stS;

  int nVec = 0;
  int nErr = 0;

  // reference model state
  int                mCntW [NUM_CH];
  int                mCntS [NUM_CH];
  int                mShW  [NUM_CH];
  int                mShS  [NUM_CH];
  logic [NUM_CH-1:0] mOvfW, mOvfS;
  int                mState;
  int                expRdW, expRdS;
  bit                expAck;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT_MODE(1'b0)) dutW (
    .clk(clk), .rst_n(rst_n), .start(start), .freeze(freeze), .clr(clr),
    .evt(evt), .rd_sel(rd_sel), .rd_src(rd_src), .snap_req(snap_req),
    .snap_ack(ackW), .rd_data(rdW), .ovf(ovfW), .state(stW)
  );

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT_MODE(1'b1)) dutS (
    .clk(clk), .rst_n(rst_n), .start(start), .freeze(freeze), .clr(clr),
    .evt(evt), .rd_sel(rd_sel), .rd_src(rd_src), .snap_req(snap_req),
    .snap_ack(ackS), .rd_data(rdS), .ovf(ovfS), .state(stS)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance model by one edge from the currently driven inputs, then check.
  task automatic step();
    expRdW = 0;
    expRdS = 0;
    if (rd_sel < NUM_CH) begin
      expRdW = (SNAP && rd_src) ? mShW[rd_sel] : mCntW[rd_sel];
      expRdS = (SNAP && rd_src) ? mShS[rd_sel] : mCntS[rd_sel];
    end
    expAck = SNAP && snap_req;
    if (SNAP && snap_req) begin
      mShW = mCntW;
      mShS = mCntS;
    end
    if (clr) begin
      for (int n = 0; n < NUM_CH; n++) begin mCntW[n] = 0; mCntS[n] = 0; end
      mOvfW = '0; mOvfS = '0; mState = 0;
    end else begin
      if (mState == 1) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (evt[n]) begin
            if (mCntW[n] == MAXV) mOvfW[n] = 1'b1;
            if (mCntS[n] == MAXV) mOvfS[n] = 1'b1;
            mCntW[n] = (mCntW[n] + 1) % (MAXV + 1);
            mCntS[n] = (mCntS[n] + 1 > MAXV) ? MAXV : mCntS[n] + 1;
          end
        end
      end
      if (mState == 0 && start)       mState = 1;
      else if (mState == 1 && freeze) mState = 2;
    end
    if (!rst_n) begin
      for (int n = 0; n < NUM_CH; n++) begin
        mCntW[n] = 0; mCntS[n] = 0; mShW[n] = 0; mShS[n] = 0;
      end
      mOvfW = '0; mOvfS = '0; mState = 0;
      expRdW = 0; expRdS = 0; expAck = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("stateW", stW, mState);
    chk("stateS", stS, mState);
    chk("rdW", rdW, expRdW);
    chk("rdS", rdS, expRdS);
    chk("ovfW", ovfW, mOvfW);
    chk("ovfS", ovfS, mOvfS);
    chk("ackW", ackW, expAck);
    chk("ackS", ackS, expAck);
  endtask

  task automatic idle_inputs();
    start = 0; freeze = 0; clr = 0; evt = '0; snap_req = 0; rd_src = 0; rd_sel = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    for (int n = 0; n < NUM_CH; n++) begin
      mCntW[n] = 0; mCntS[n] = 0; mShW[n] = 0; mShS[n] = 0;
    end
    mOvfW = '0; mOvfS = '0; mState = 0;

    // reset, then count 10 events on ch0
    step(); step();
    chk("rst_rd", rdW, 0);
    rst_n = 1; start = 1; step();
    start = 0; evt = 6'b000001;
    repeat (10) step();
    evt = '0; step();
    chk("cnt10", rdW, 10);
    chk("run_state", stW, 2'b01);

    // freeze in the same cycle as all-channel events
    clr = 1; step(); clr = 0;
    start = 1; step(); start = 0;
    evt = 6'b111111; freeze = 1; step();
    repeat (5) step();
    evt = '0; freeze = 0;
    for (int n = 0; n < NUM_CH; n++) begin
      rd_sel = 4'(n); step();
      chk("frz_cnt", rdW, 1);
    end
    step();
    chk("frz_state", stW, 2'b10);

    // 256 events on ch2: wrap vs saturate
    clr = 1; step(); clr = 0;
    start = 1; step(); start = 0;
    evt = 6'b000100;
    repeat (256) step();
    evt = '0; rd_sel = 2; step(); step();
    chk("wrap_cnt", rdW, 0);
    chk("sat_cnt", rdS, MAXV);
    chk("wrap_ovf", ovfW[2], 1);
    chk("sat_ovf", ovfS[2], 1);

    // snapshot at ch1 = 7
    clr = 1; step(); clr = 0;
    start = 1; step(); start = 0;
    evt = 6'b000010; repeat (7) step();
    snap_req = 1; step();
    snap_req = 0; evt = '0;
    chk("snap_ack", ackW, SNAP);
    rd_sel = 1; rd_src = 1; step();
    chk("snap_rd", rdW, SNAP ? 7 : 8);
    rd_src = 0; step();
    chk("live_rd", rdW, 8);
    clr = 1; step(); clr = 0;
    rd_src = 1; step();
    chk("snap_keep", rdW, SNAP ? 7 : 0);
    rd_src = 0;

    // clr and start together in RUN
    start = 1; step(); start = 0;
    evt = 6'b101011; repeat (3) step(); evt = '0;
    clr = 1; start = 1; step(); clr = 0; start = 0;
    rd_sel = 9; step();
    chk("clrstart_st", stW, 2'b00);
    chk("clrstart_ovf", ovfW, 0);
    chk("oob_rd", rdW, 0);

    // reset during snapshot request
    snap_req = 1; step();
    rst_n = 0; step();
    rst_n = 1; snap_req = 0; step();
    chk("rst_noack", ackW, 0);
    chk("rst_state", stW, 2'b00);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      clr      = ($urandom_range(0, 59) == 0);
      freeze   = ($urandom_range(0, 79) == 0);
      start    = ($urandom_range(0, 3) == 0);
      snap_req = ($urandom_range(0, 4) == 0);
      rd_src   = $urandom_range(0, 1);
      rd_sel   = 4'($urandom_range(0, 15));
      evt      = NUM_CH'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
